dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_addr_check.sv | 30 +++
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its address checker.
package dmem_pkg;

    localparam int unsigned ADDR_W       = 11;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned DEF_BASE     = 1024;
    localparam int unsigned DEF_LIMIT    = 1280;
    localparam int unsigned DEF_MAX_LOCK = 8;

    typedef logic port_id_t;

    typedef enum logic [1:0] {
        LK_IDLE = 2'b00,
        LK_P0   = 2'b01,
        LK_P1   = 2'b10
    } lock_state_e;

    typedef struct packed {
        port_id_t            port;
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic                legal;
    } issue_t;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bus of the two-port data-memory arbiter.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic                req0;
    logic                req1;
    logic                we0;
    logic                we1;
    logic                lock0;
    logic                lock1;
    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   addr1;
    logic [DATA_W-1:0]   wdata0;
    logic [DATA_W-1:0]   wdata1;
    logic                gnt0;
    logic                gnt1;
    logic                rvalid0;
    logic                rvalid1;
    logic [DATA_W-1:0]   rdata;
    logic                rerr;
    logic                memWrite;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memData;
    logic [DATA_W-1:0]   memOut;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, memOut,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, rerr, memWrite, memAddr, memData
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, memOut,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, rerr, memWrite, memAddr, memData
    );

endinterface

// File: rtl/dmem_addr_check.sv
// Combinational legality of a data access: address window plus word alignment for writes.
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int unsigned BASE  = DEF_BASE,
    parameter int unsigned LIMIT = DEF_LIMIT
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic              legal
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(LIMIT);

    logic in_range_s;
    logic aligned_s;

    // Reads may be unaligned; only writes must hit a word boundary.
    always_comb begin
        in_range_s = (addr >= BASE_A) && (addr <= LIMIT_A);
        if (we) begin
            aligned_s = (addr[1:0] == 2'b00);
        end else begin
            aligned_s = 1'b1;
        end
        legal = in_range_s && aligned_s;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: lock-aware grant, issue stage, fixed-latency response.
// Build option DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned BASE     = DEF_BASE,
    parameter int unsigned LIMIT    = DEF_LIMIT,
    parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic           clock,
    input  logic           resetN,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned      CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    lock_state_e        lock_state_r;
    lock_state_e        lock_state_next_s;
    logic [CNT_W-1:0]   lock_cnt_r;
    logic [CNT_W-1:0]   lock_cnt_next_s;

    logic [1:0]         req_s;
    logic [1:0]         lock_s;
    logic               owner_valid_s;
    port_id_t           owner_s;
    logic               owner_hold_s;
    logic               owner_ok_s;
    port_id_t           sel_s;
    logic               gnt_any_s;
    logic               acc_lock_s;
    logic               acc_legal_s;
    issue_t             acc_s;

    logic               issue_valid_r;
    issue_t             issue_r;
    logic [1:0]         rvalid_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               rerr_r;

`ifdef DMEM_ARB_RR_EN
    port_id_t           rr_ptr_r;
`endif

    // Decode the lock owner from the lock FSM state.
    always_comb begin
        owner_valid_s = 1'b0;
        owner_s       = 1'b0;
        case (lock_state_r)
            LK_IDLE: begin
                owner_valid_s = 1'b0;
                owner_s       = 1'b0;
            end
            LK_P0: begin
                owner_valid_s = 1'b1;
                owner_s       = 1'b0;
            end
            LK_P1: begin
                owner_valid_s = 1'b1;
                owner_s       = 1'b1;
            end
            default: begin
                owner_valid_s = 1'b0;
                owner_s       = 1'b0;
            end
        endcase
    end

    // Grant selection: a valid lock owner below the bound wins, else the policy decides.
    always_comb begin
        req_s        = {bus.req1, bus.req0};
        lock_s       = {bus.lock1, bus.lock0};
        owner_hold_s = req_s[owner_s] && lock_s[owner_s];
        owner_ok_s   = owner_valid_s && owner_hold_s && (lock_cnt_r < MAX_CNT);
        sel_s        = 1'b0;
        if (owner_ok_s) begin
            sel_s = owner_s;
        end else if (req_s == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            sel_s = rr_ptr_r;
`else
            sel_s = 1'b0;
`endif
        end else if (req_s[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        // Grants are suppressed while reset is held so nothing is accepted.
        gnt_any_s = (|req_s) && resetN;
    end

    assign bus.gnt0 = gnt_any_s && (sel_s == 1'b0);
    assign bus.gnt1 = gnt_any_s && (sel_s == 1'b1);

    dmem_addr_check #(
        .BASE  (BASE),
        .LIMIT (LIMIT)
    ) u_addr_check (
        .addr  (sel_s ? bus.addr1 : bus.addr0),
        .we    (sel_s ? bus.we1   : bus.we0),
        .legal (acc_legal_s)
    );

    // Assemble the accepted access from the granted port.
    always_comb begin
        acc_lock_s  = sel_s ? bus.lock1 : bus.lock0;
        acc_s.port  = sel_s;
        acc_s.we    = sel_s ? bus.we1    : bus.we0;
        acc_s.addr  = sel_s ? bus.addr1  : bus.addr0;
        acc_s.wdata = sel_s ? bus.wdata1 : bus.wdata0;
        acc_s.legal = acc_legal_s;
    end

    // Lock FSM next state and consecutive-grant counter.
    always_comb begin
        lock_state_next_s = lock_state_r;
        lock_cnt_next_s   = lock_cnt_r;
        if (gnt_any_s) begin
            if (acc_lock_s) begin
                lock_state_next_s = sel_s ? LK_P1 : LK_P0;
                if (owner_ok_s) begin
                    lock_cnt_next_s = lock_cnt_r + ONE_CNT;
                end else begin
                    lock_cnt_next_s = ONE_CNT;
                end
            end else begin
                lock_state_next_s = LK_IDLE;
                lock_cnt_next_s   = '0;
            end
        end else if (owner_valid_s && !owner_hold_s) begin
            lock_state_next_s = LK_IDLE;
            lock_cnt_next_s   = '0;
        end else begin
            lock_state_next_s = lock_state_r;
            lock_cnt_next_s   = lock_cnt_r;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lock_state_r <= LK_IDLE;
            lock_cnt_r   <= '0;
        end else begin
            lock_state_r <= lock_state_next_s;
            lock_cnt_r   <= lock_cnt_next_s;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Round-robin pointer favours the port that was not granted last.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rr_ptr_r <= 1'b0;
        end else if (gnt_any_s) begin
            rr_ptr_r <= other_port(sel_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Issue stage: latch the accepted access for the memory cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            issue_valid_r <= 1'b0;
            issue_r       <= '0;
        end else begin
            issue_valid_r <= gnt_any_s;
            if (gnt_any_s) begin
                issue_r <= acc_s;
            end else begin
                issue_r <= issue_r;
            end
        end
    end

    assign bus.memWrite = issue_valid_r && issue_r.we && issue_r.legal;
    assign bus.memAddr  = issue_r.addr;
    assign bus.memData  = issue_r.wdata;

    // Response stage: read data only for legal reads; writes and errors return zero.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rvalid_r <= 2'b00;
            rdata_r  <= '0;
            rerr_r   <= 1'b0;
        end else begin
            rvalid_r[0] <= issue_valid_r && (issue_r.port == 1'b0);
            rvalid_r[1] <= issue_valid_r && (issue_r.port == 1'b1);
            rerr_r      <= issue_valid_r && !issue_r.legal;
            if (issue_valid_r && !issue_r.we && issue_r.legal) begin
                rdata_r <= bus.memOut;
            end else begin
                rdata_r <= '0;
            end
        end
    end

    assign bus.rvalid0 = rvalid_r[0];
    assign bus.rvalid1 = rvalid_r[1];
    assign bus.rdata   = rdata_r;
    assign bus.rerr    = rerr_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory on the memory side.
module tb_dmem_arbiter;

    logic clock;
    logic resetN;
    int   errors;
    int   checks;
    int   n_gnt1;

    logic [31:0] mem [512] = '{default: 32'h0};

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.memOut = mem[bus.memAddr[10:2]];

    always @(posedge clock) begin
        if (bus.memWrite) begin
            mem[bus.memAddr[10:2]] <= bus.memData;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        n_gnt1 = 0;
        resetN = 1'b0;
        bus.req0 = 1'b1;  bus.we0 = 1'b1;  bus.lock0 = 1'b0;
        bus.addr0 = 11'd1028; bus.wdata0 = 32'hDEADBEEF;
        bus.req1 = 1'b0;  bus.we1 = 1'b0;  bus.lock1 = 1'b0;
        bus.addr1 = 11'd0;    bus.wdata1 = 32'h0;

        // reset held with a pending write
        tick();
        tick();
        chk("rst_gnt0",     32'(bus.gnt0),     32'h0);
        chk("rst_gnt1",     32'(bus.gnt1),     32'h0);
        chk("rst_memWrite", 32'(bus.memWrite), 32'h0);
        chk("rst_rvalid0",  32'(bus.rvalid0),  32'h0);
        chk("rst_rvalid1",  32'(bus.rvalid1),  32'h0);
        chk("rst_rdata",    bus.rdata,         32'h0);
        chk("rst_rerr",     32'(bus.rerr),     32'h0);
        chk("rst_memAddr",  32'(bus.memAddr),  32'h0);
        chk("rst_memData",  bus.memData,       32'h0);

        resetN = 1'b1;
        #1;
        chk("rel_gnt0", 32'(bus.gnt0), 32'h1);

        // write then back-to-back read of the same address
        tick();
        chk("wr_memWrite", 32'(bus.memWrite), 32'h1);
        chk("wr_memAddr",  32'(bus.memAddr),  32'd1028);
        chk("wr_memData",  bus.memData,       32'hDEADBEEF);
        bus.we0 = 1'b0;
        #1;
        chk("rd_gnt0", 32'(bus.gnt0), 32'h1);
        tick();
        chk("wr_rvalid0",  32'(bus.rvalid0),  32'h1);
        chk("wr_rdata",    bus.rdata,         32'h0);
        chk("wr_rerr",     32'(bus.rerr),     32'h0);
        chk("rd_memWrite", 32'(bus.memWrite), 32'h0);
        bus.req0 = 1'b0;
        tick();
        chk("rd_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("rd_rdata",   bus.rdata,        32'hDEADBEEF);
        chk("rd_rerr",    32'(bus.rerr),    32'h0);
        tick();
        chk("rd_rvalid0_end", 32'(bus.rvalid0), 32'h0);

        // port 1 write and read at LIMIT (legal)
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 11'd1280; bus.wdata1 = 32'hA5A50001;
        #1;
        chk("lim_gnt1", 32'(bus.gnt1), 32'h1);
        tick();
        chk("lim_memWrite", 32'(bus.memWrite), 32'h1);
        bus.we1 = 1'b0;
        tick();
        chk("lim_wr_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("lim_wr_rerr",    32'(bus.rerr),    32'h0);
        bus.req1 = 1'b0;
        tick();
        chk("lim_rd_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("lim_rd_rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("lim_rd_rdata",   bus.rdata,        32'hA5A50001);
        chk("lim_rd_rerr",    32'(bus.rerr),    32'h0);
        tick();

        // illegal accesses: misaligned write, above LIMIT, below BASE
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 11'd1026; bus.wdata0 = 32'h12345678;
        #1;
        chk("err_gnt0", 32'(bus.gnt0), 32'h1);
        tick();
        chk("mis_memWrite", 32'(bus.memWrite), 32'h0);
        bus.we0 = 1'b0; bus.addr0 = 11'd1281;
        tick();
        chk("hi_memWrite", 32'(bus.memWrite), 32'h0);
        chk("mis_rvalid0", 32'(bus.rvalid0),  32'h1);
        chk("mis_rerr",    32'(bus.rerr),     32'h1);
        chk("mis_rdata",   bus.rdata,         32'h0);
        bus.addr0 = 11'd1023;
        tick();
        chk("lo_memWrite", 32'(bus.memWrite), 32'h0);
        chk("hi_rvalid0",  32'(bus.rvalid0),  32'h1);
        chk("hi_rerr",     32'(bus.rerr),     32'h1);
        chk("hi_rdata",    bus.rdata,         32'h0);
        bus.req0 = 1'b0;
        tick();
        chk("lo_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("lo_rerr",    32'(bus.rerr),    32'h1);
        chk("lo_rdata",   bus.rdata,        32'h0);
        tick();

        // contention from a fresh reset: both ports read for four cycles
        resetN = 1'b0;
        #1;
        resetN = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 11'd1028;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 11'd1280;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef DMEM_ARB_RR_EN
            chk("cont_gnt0", 32'(bus.gnt0), ((i % 2) == 0) ? 32'h1 : 32'h0);
            chk("cont_gnt1", 32'(bus.gnt1), ((i % 2) == 0) ? 32'h0 : 32'h1);
`else
            chk("cont_gnt0", 32'(bus.gnt0), 32'h1);
            chk("cont_gnt1", 32'(bus.gnt1), 32'h0);
`endif
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        tick();

        // lock bound: port 1 takes ownership, then port 0 also requests
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 11'd1280;
        #1;
        chk("lock_first_gnt1", 32'(bus.gnt1), 32'h1);
        if (bus.gnt1) n_gnt1++;
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 11'd1028;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (bus.gnt1) n_gnt1++;
            if (i < 8) begin
                chk("lock_hold_gnt1", 32'(bus.gnt1), 32'h1);
                chk("lock_hold_gnt0", 32'(bus.gnt0), 32'h0);
            end else begin
                chk("lock_rel_gnt0", 32'(bus.gnt0), 32'h1);
                chk("lock_rel_gnt1", 32'(bus.gnt1), 32'h0);
            end
            tick();
        end
        chk("lock_gnt1_count", 32'(n_gnt1), 32'd8);
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
        tick();
        tick();
        tick();

        // reset in the cycle after a write grant
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 11'd1036; bus.wdata0 = 32'h11112222;
        #1;
        chk("mfr_gnt0", 32'(bus.gnt0), 32'h1);
        @(posedge clock);
        #1;
        resetN = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("mfr_memWrite", 32'(bus.memWrite), 32'h0);
        chk("mfr_rvalid0",  32'(bus.rvalid0),  32'h0);
        tick();
        chk("mfr_memWrite_hold", 32'(bus.memWrite), 32'h0);
        resetN = 1'b1;
        tick();
        chk("mfr_rvalid0_a", 32'(bus.rvalid0), 32'h0);
        tick();
        chk("mfr_rvalid0_b", 32'(bus.rvalid0), 32'h0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 11'd1036;
        #1;
        chk("mfr_rd_gnt0", 32'(bus.gnt0), 32'h1);
        tick();
        bus.req0 = 1'b0;
        tick();
        chk("mfr_rd_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("mfr_rd_rdata",   bus.rdata,        32'h0);
        chk("mfr_rd_rerr",    32'(bus.rerr),    32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
